// File: rtl/mem_arbiter.sv
// mem_arbiter: shared SDRAM byte-port arbiter for loader, FDD buffer and CPU.
// Fixed-latency command sequencing with alternating FDD/CPU sharing.
module mem_arbiter #(
  parameter int          RD_LAT   = 4,
  parameter int          WR_LAT   = 4,
  parameter logic [24:0] FDD_BASE = 25'h0100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ld_req,
  input  logic [24:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic        ld_ack,
  input  logic        fdd_req,
  input  logic [19:0] fdd_addr,
  output logic        fdd_ack,
  output logic [7:0]  fdd_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  output logic        busy
);

  localparam int MAXL = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] RD_LD = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_LD = CW'(WR_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic [2:0]    r_gnt;
  logic          r_we;
  logic          r_last_fdd;
  logic [24:0]   r_addr;
  logic [7:0]    r_din;
  logic [7:0]    r_fdd_rdata;
  logic [7:0]    r_cpu_rdata;
  logic [CW-1:0] r_cnt;
  logic          r_ld_ack;
  logic          r_fdd_ack;
  logic          r_cpu_ack;

  logic          w_gnt_ld;
  logic          w_gnt_fdd;
  logic          w_gnt_cpu;
  logic          w_any;
  logic          w_to_done;
  logic [CW-1:0] w_ld_val;

  // FDD and CPU alternate: the one not served last wins a tie
  assign w_gnt_ld  = ld_req;
  assign w_gnt_fdd = !ld_req && fdd_req && (!cpu_req || !r_last_fdd);
  assign w_gnt_cpu = !ld_req && cpu_req && (!fdd_req || r_last_fdd);
  assign w_any     = ld_req | fdd_req | cpu_req;

  assign w_ld_val  = r_we ? WR_LD : RD_LD;
  assign w_to_done = ((r_state == S_ISSUE) && (w_ld_val == '0)) ||
                     ((r_state == S_WAIT) && (r_cnt == CW'(1)));

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_nstate = S_ISSUE;
      S_ISSUE: w_nstate = w_to_done ? S_DONE : S_WAIT;
      S_WAIT:  if (w_to_done) w_nstate = S_DONE;
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nstate;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt       <= '0;
      r_we        <= 1'b0;
      r_last_fdd  <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_fdd_rdata <= '0;
      r_cpu_rdata <= '0;
      r_cnt       <= '0;
      r_ld_ack    <= 1'b0;
      r_fdd_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_gnt <= {w_gnt_ld, w_gnt_fdd, w_gnt_cpu};
        unique case (1'b1)
          w_gnt_ld: begin
            r_addr <= ld_addr;
            r_din  <= ld_wdata;
            r_we   <= 1'b1;
          end
          w_gnt_fdd: begin
            r_addr <= FDD_BASE | {5'b0, fdd_addr};
            r_din  <= '0;
            r_we   <= 1'b0;
          end
          w_gnt_cpu: begin
            r_addr <= cpu_addr;
            r_din  <= cpu_wdata;
            r_we   <= cpu_we;
          end
          default: ;
        endcase
      end
      if (r_state == S_ISSUE) r_cnt <= w_ld_val;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - CW'(1);
      // ack, read data and fairness bit all update on the edge into DONE
      r_ld_ack  <= w_to_done & r_gnt[2];
      r_fdd_ack <= w_to_done & r_gnt[1];
      r_cpu_ack <= w_to_done & r_gnt[0];
      if (w_to_done) begin
        if (!r_we && r_gnt[1]) r_fdd_rdata <= mem_dout;
        if (!r_we && r_gnt[0]) r_cpu_rdata <= mem_dout;
        if (r_gnt[1])      r_last_fdd <= 1'b1;
        else if (r_gnt[0]) r_last_fdd <= 1'b0;
      end
    end
  end

  assign mem_we    = (r_state == S_ISSUE) & r_we;
  assign mem_rd    = (r_state == S_ISSUE) & ~r_we;
  assign mem_addr  = r_addr;
  assign mem_din   = r_din;
  assign ld_ack    = r_ld_ack;
  assign fdd_ack   = r_fdd_ack;
  assign cpu_ack   = r_cpu_ack;
  assign fdd_rdata = r_fdd_rdata;
  assign cpu_rdata = r_cpu_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random requests against a reference model.
// A small SRAM stand-in returns read data RD_LAT-1 cycles after the strobe cycle.
module tb_mem_arbiter;

  localparam int          RD_LAT   = 4;
  localparam int          WR_LAT   = 1;
  localparam logic [24:0] FDD_BASE = 25'h0100000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ld_req;
  logic [24:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_ack;
  logic        fdd_req;
  logic [19:0] fdd_addr;
  logic        fdd_ack;
  logic [7:0]  fdd_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .RD_LAT(RD_LAT),
    .WR_LAT(WR_LAT),
    .FDD_BASE(FDD_BASE)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ld_req(ld_req),
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_ack(ld_ack),
    .fdd_req(fdd_req),
    .fdd_addr(fdd_addr),
    .fdd_ack(fdd_ack),
    .fdd_rdata(fdd_rdata),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_we(mem_we),
    .mem_rd(mem_rd),
    .mem_dout(mem_dout),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] defval(logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b0, a[24:20]} ^ 8'h5A;
  endfunction

  // SRAM stand-in
  logic [7:0] sram [logic [24:0]];
  logic [24:0] s_raddr = '0;
  int          s_cnt = 0;
  logic [7:0]  s_dout = 8'hEE;
  assign mem_dout = s_dout;

  always @(posedge clk_sys) begin
    if (mem_we) sram[mem_addr] = mem_din;
    if (mem_rd) begin
      s_raddr <= mem_addr;
      s_cnt   <= RD_LAT - 1;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
    end
    if (!mem_rd && s_cnt == 2)
      s_dout <= sram.exists(s_raddr) ? sram[s_raddr] : defval(s_raddr);
    else
      s_dout <= 8'hEE;
  end

  // reference model state
  logic [7:0] ref_mem [logic [24:0]];
  logic       m_last_fdd = 1'b0;
  logic [7:0] m_fdd_rd = '0;
  logic [7:0] m_cpu_rd = '0;

  function automatic logic [7:0] ref_rd(logic [24:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : defval(a);
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_acks"}, {29'b0, ld_ack, fdd_ack, cpu_ack}, 32'd0);
    chk({tag, "_strb"}, {30'b0, mem_we, mem_rd}, 32'd0);
  endtask

  // Called in an IDLE cycle with at least one req pending; returns the
  // winner (0 loader, 1 fdd, 2 cpu) and ends in the following IDLE cycle.
  task automatic access(output int who);
    logic [24:0] ea;
    logic [7:0]  ed;
    logic        ew;
    int          lat;
    if (ld_req)                  who = 0;
    else if (fdd_req && cpu_req) who = m_last_fdd ? 2 : 1;
    else if (fdd_req)            who = 1;
    else                         who = 2;
    case (who)
      0:       begin ea = ld_addr; ed = ld_wdata; ew = 1'b1; end
      1:       begin ea = FDD_BASE | {5'b0, fdd_addr}; ed = '0; ew = 1'b0; end
      default: begin ea = cpu_addr; ed = cpu_wdata; ew = cpu_we; end
    endcase
    lat = ew ? WR_LAT : RD_LAT;
    tick();
    chk("issue_we", {31'b0, mem_we}, {31'b0, ew});
    chk("issue_rd", {31'b0, mem_rd}, {31'b0, !ew});
    chk("issue_addr", {7'b0, mem_addr}, {7'b0, ea});
    if (ew) chk("issue_din", {24'b0, mem_din}, {24'b0, ed});
    chk("issue_busy", {31'b0, busy}, 32'd1);
    chk("issue_acks", {29'b0, ld_ack, fdd_ack, cpu_ack}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk_quiet("wait");
      chk("wait_busy", {31'b0, busy}, 32'd1);
      chk("wait_addr", {7'b0, mem_addr}, {7'b0, ea});
    end
    tick();
    if (ew) ref_mem[ea] = ed;
    else if (who == 1) m_fdd_rd = ref_rd(ea);
    else m_cpu_rd = ref_rd(ea);
    if (who != 0) m_last_fdd = (who == 1);
    chk("done_ack", {29'b0, ld_ack, fdd_ack, cpu_ack},
        32'(3'b100 >> who));
    chk("done_fdd_rdata", {24'b0, fdd_rdata}, {24'b0, m_fdd_rd});
    chk("done_cpu_rdata", {24'b0, cpu_rdata}, {24'b0, m_cpu_rd});
    chk("done_strb", {30'b0, mem_we, mem_rd}, 32'd0);
    tick();
    chk_quiet("idle");
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int who;
    reset_n   = 1'b0;
    ld_req    = 1'b0;
    ld_addr   = '0;
    ld_wdata  = '0;
    fdd_req   = 1'b0;
    fdd_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    sram[25'h000C000]    = 8'hA5;
    ref_mem[25'h000C000] = 8'hA5;

    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk_quiet("rst");
    chk("rst_addr", {7'b0, mem_addr}, 32'd0);
    chk("rst_din", {24'b0, mem_din}, 32'd0);
    chk("rst_fdd_rdata", {24'b0, fdd_rdata}, 32'd0);
    chk("rst_cpu_rdata", {24'b0, cpu_rdata}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk_quiet("post_rst");

    // single CPU read
    cpu_we   = 1'b0;
    cpu_addr = 25'h000C000;
    cpu_req  = 1'b1;
    access(who);
    chk("t1_who", 32'(who), 32'd2);
    chk("t1_rdata", {24'b0, cpu_rdata}, 32'h0000_00A5);
    cpu_req = 1'b0;

    // FDD and CPU tie, four alternating grants
    fdd_addr = 20'h00123;
    cpu_addr = 25'h0000040;
    fdd_req  = 1'b1;
    cpu_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      access(who);
      chk("t2_order", 32'(who), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    fdd_req = 1'b0;
    cpu_req = 1'b0;

    // loader priority over a pending FDD/CPU pair
    fdd_req = 1'b1;
    cpu_req = 1'b1;
    ld_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_addr  = 25'h0100200 + 25'(i);
      ld_wdata = 8'h90 + 8'(i);
      access(who);
      chk("t3_ld", 32'(who), 32'd0);
    end
    ld_req = 1'b0;
    fdd_addr = 20'h00201;
    access(who);
    chk("t3_fdd", 32'(who), 32'd1);
    chk("t3_fdd_data", {24'b0, fdd_rdata}, 32'h0000_0091);
    fdd_req = 1'b0;
    access(who);
    chk("t3_cpu", 32'(who), 32'd2);
    cpu_req = 1'b0;

    // CPU write, single-cycle write latency
    cpu_we    = 1'b1;
    cpu_addr  = 25'h0009000;
    cpu_wdata = 8'h3C;
    cpu_req   = 1'b1;
    access(who);
    chk("t4_who", 32'(who), 32'd2);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;

    // reset in the middle of a CPU read
    cpu_addr = 25'h000C000;
    cpu_req  = 1'b1;
    tick();
    chk("t5_issue_rd", {31'b0, mem_rd}, 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk_quiet("t5_rst");
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_addr", {7'b0, mem_addr}, 32'd0);
    chk("t5_cpu_rdata", {24'b0, cpu_rdata}, 32'd0);
    m_last_fdd = 1'b0;
    m_fdd_rd   = '0;
    m_cpu_rd   = '0;
    tick();
    tick();
    chk_quiet("t5_hold");
    reset_n = 1'b1;
    access(who);
    chk("t5_regrant", 32'(who), 32'd2);

    // req left high after ack is a new request
    access(who);
    chk("t6_again", 32'(who), 32'd2);
    cpu_req = 1'b0;

    // random traffic against the model
    for (int k = 0; k < 80; k++) begin
      if (!ld_req && $urandom_range(0, 3) == 0) begin
        ld_addr  = ($urandom_range(0, 1) != 0 ? FDD_BASE : 25'h0) |
                   25'($urandom_range(0, 31));
        ld_wdata = 8'($urandom);
        ld_req   = 1'b1;
      end
      if (!fdd_req && $urandom_range(0, 1) != 0) begin
        fdd_addr = 20'($urandom_range(0, 31));
        fdd_req  = 1'b1;
      end
      if (!cpu_req && $urandom_range(0, 1) != 0) begin
        cpu_we    = 1'($urandom);
        cpu_addr  = 25'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
        cpu_req   = 1'b1;
      end
      if (ld_req || fdd_req || cpu_req) begin
        access(who);
        case (who)
          0:       ld_req  = 1'b0;
          1:       fdd_req = 1'b0;
          default: cpu_req = 1'b0;
        endcase
      end else begin
        tick();
        chk_quiet("rnd_idle");
        chk("rnd_idle_busy", {31'b0, busy}, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
